// File: rtl/pixel_stream_sink_pkg.sv
// rtl/pixel_stream_sink_pkg.sv - register map, CTRL bit positions and FSM states for pixel_stream_sink
package pixel_stream_sink_pkg;

  localparam logic [4:0] REG_CTRL        = 5'h00;
  localparam logic [4:0] REG_STATUS      = 5'h04;
  localparam logic [4:0] REG_CHECKSUM    = 5'h08;
  localparam logic [4:0] REG_STATS       = 5'h0C;
  localparam logic [4:0] REG_EXPECT_BASE = 5'h10;
  localparam logic [4:0] REG_MISMATCH    = 5'h14;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_CLR_BIT     = 1;
  localparam int CTRL_ONESHOT_BIT = 2;

  localparam int IDX_W = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_LATCH  = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_frame_stats.sv
// rtl/pixel_frame_stats.sv - x/y/index counters and running sum, xor, min, max of one frame
module pixel_frame_stats
  import pixel_stream_sink_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int PIX_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_xfer,
  input  logic [PIX_W-1:0] i_pixel,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic [23:0]      o_sum,
  output logic [PIX_W-1:0] o_xor,
  output logic [PIX_W-1:0] o_min,
  output logic [PIX_W-1:0] o_max,
  output logic [IDX_W-1:0] o_last_idx
);

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);

  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic [23:0]      r_sum;
  logic [PIX_W-1:0] r_xor;
  logic [PIX_W-1:0] r_min;
  logic [PIX_W-1:0] r_max;
  logic             w_x_end;
  logic             w_y_end;

  assign w_x_end = (r_x == X_W'(WIDTH - 1));
  assign w_y_end = (r_y == Y_W'(HEIGHT - 1));

  // clear wins over a transfer in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x        <= '0;
      r_y        <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_sum      <= '0;
      r_xor      <= '0;
      r_min      <= '1;
      r_max      <= '0;
    end else if (i_clear) begin
      r_x        <= '0;
      r_y        <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_sum      <= '0;
      r_xor      <= '0;
      r_min      <= '1;
      r_max      <= '0;
    end else if (i_xfer) begin
      r_x        <= w_x_end ? '0 : r_x + 1'b1;
      if (w_x_end) begin
        r_y <= w_y_end ? '0 : r_y + 1'b1;
      end
      r_idx      <= (w_x_end && w_y_end) ? '0 : r_idx + 1'b1;
      r_last_idx <= r_idx;
      r_sum      <= r_sum + 24'(i_pixel);
      r_xor      <= r_xor ^ i_pixel;
      if (i_pixel < r_min) r_min <= i_pixel;
      if (i_pixel > r_max) r_max <= i_pixel;
    end
  end

  assign o_idx      = r_idx;
  assign o_last     = w_x_end && w_y_end;
  assign o_sum      = r_sum;
  assign o_xor      = r_xor;
  assign o_min      = r_min;
  assign o_max      = r_max;
  assign o_last_idx = r_last_idx;

endmodule

// File: rtl/pixel_stream_sink.sv
// rtl/pixel_stream_sink.sv - frame-counting pixel sink with checksum/stats registers
// Optional pixel sequence checking is compiled in with PIXEL_CHECK_EN.
module pixel_stream_sink
  import pixel_stream_sink_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int PIX_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [4:0]       addr_in,
  input  logic [31:0]      wr_data_in,
  input  logic             write_en,
  output logic [31:0]      rd_data_out,
  output logic             frame_done
);

  state_t           r_state;
  state_t           w_next;
  logic             r_en;
  logic             r_oneshot;
  logic [15:0]      r_frame_cnt;
  logic [23:0]      r_chk_sum;
  logic [PIX_W-1:0] r_chk_xor;
  logic [PIX_W-1:0] r_min;
  logic [PIX_W-1:0] r_max;
  logic [IDX_W-1:0] r_stat_idx;

  logic             w_wr_ctrl;
  logic             w_clr;
  logic             w_xfer;
  logic             w_stats_clear;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic [23:0]      w_sum;
  logic [PIX_W-1:0] w_xor;
  logic [PIX_W-1:0] w_min;
  logic [PIX_W-1:0] w_max;
  logic [IDX_W-1:0] w_last_idx;
  logic [7:0]       w_expect_base;
  logic [31:0]      w_mismatch;
  logic             w_sticky;
  logic             w_unused;

  assign w_wr_ctrl = write_en && (addr_in == REG_CTRL);
  assign w_clr     = w_wr_ctrl && wr_data_in[CTRL_CLR_BIT];
  assign w_xfer    = valid_in && ready_out;
  // accumulators stay clean outside ACTIVE, and a disabled partial frame is dropped
  assign w_stats_clear = w_clr || (r_state != S_ACTIVE) || !r_en;

  pixel_frame_stats #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .PIX_W (PIX_W)
  ) u_stats (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (w_stats_clear),
    .i_xfer    (w_xfer),
    .i_pixel   (pixel_in),
    .o_idx     (w_idx),
    .o_last    (w_last),
    .o_sum     (w_sum),
    .o_xor     (w_xor),
    .o_min     (w_min),
    .o_max     (w_max),
    .o_last_idx(w_last_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_en) w_next = S_ACTIVE;
      S_ACTIVE: begin
        if (w_clr)                 w_next = S_ACTIVE;
        else if (!r_en)            w_next = S_IDLE;
        else if (w_xfer && w_last) w_next = S_LATCH;
      end
      S_LATCH:  w_next = (r_en && !r_oneshot) ? S_ACTIVE : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out  = (r_state == S_ACTIVE);
    frame_done = (r_state == S_LATCH);
  end

  // a CTRL write in the LATCH cycle overrides the one-shot auto-disable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en        <= 1'b0;
      r_oneshot   <= 1'b0;
      r_frame_cnt <= '0;
      r_chk_sum   <= '0;
      r_chk_xor   <= '0;
      r_min       <= '1;
      r_max       <= '0;
      r_stat_idx  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en      <= wr_data_in[CTRL_EN_BIT];
        r_oneshot <= wr_data_in[CTRL_ONESHOT_BIT];
      end else if ((r_state == S_LATCH) && r_oneshot) begin
        r_en <= 1'b0;
      end
      if (w_clr) begin
        r_frame_cnt <= '0;
        r_chk_sum   <= '0;
        r_chk_xor   <= '0;
        r_min       <= '1;
        r_max       <= '0;
        r_stat_idx  <= '0;
      end else if (r_state == S_LATCH) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_chk_sum   <= w_sum;
        r_chk_xor   <= w_xor;
        r_min       <= w_min;
        r_max       <= w_max;
        r_stat_idx  <= w_last_idx;
      end
    end
  end

`ifdef PIXEL_CHECK_EN
  logic [7:0]  r_expect_base;
  logic [31:0] r_mismatch;
  logic        r_sticky;
  logic        w_mis;

  assign w_mis = w_xfer && (pixel_in != PIX_W'(IDX_W'(r_expect_base) + w_idx));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_expect_base <= '0;
      r_mismatch    <= '0;
      r_sticky      <= 1'b0;
    end else begin
      if (write_en && (addr_in == REG_EXPECT_BASE)) r_expect_base <= wr_data_in[7:0];
      if (w_clr) begin
        r_mismatch <= '0;
        r_sticky   <= 1'b0;
      end else if (w_mis) begin
        if (r_mismatch != '1) r_mismatch <= r_mismatch + 32'd1;
        r_sticky <= 1'b1;
      end
    end
  end

  assign w_expect_base = r_expect_base;
  assign w_mismatch    = r_mismatch;
  assign w_sticky      = r_sticky;
  assign w_unused      = ^wr_data_in[31:8];
`else
  assign w_expect_base = '0;
  assign w_mismatch    = '0;
  assign w_sticky      = 1'b0;
  assign w_unused      = ^{wr_data_in[31:3], w_idx};
`endif

  always_comb begin
    rd_data_out = '0;
    case (addr_in)
      REG_CTRL: begin
        rd_data_out[CTRL_EN_BIT]      = r_en;
        rd_data_out[CTRL_ONESHOT_BIT] = r_oneshot;
      end
      REG_STATUS: begin
        rd_data_out[15:0] = r_frame_cnt;
        rd_data_out[16]   = (r_state != S_IDLE);
        rd_data_out[17]   = w_sticky;
      end
      REG_CHECKSUM: rd_data_out = {8'(r_chk_xor), r_chk_sum};
      REG_STATS: begin
        rd_data_out[7:0]   = 8'(r_min);
        rd_data_out[15:8]  = 8'(r_max);
        rd_data_out[25:16] = r_stat_idx;
      end
      REG_EXPECT_BASE: rd_data_out[7:0] = w_expect_base;
      REG_MISMATCH:    rd_data_out = w_mismatch;
      default:         rd_data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_pixel_stream_sink.sv
// tb/tb_pixel_stream_sink.sv - directed self-checking bench for pixel_stream_sink
module tb_pixel_stream_sink;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  pixel_in;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  addr_in;
  logic [31:0] wr_data_in;
  logic        write_en;
  logic [31:0] rd_data_out;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int pix_idx = 0;

  always #5 clk = ~clk;

  pixel_stream_sink #(
    .WIDTH (32),
    .HEIGHT(32),
    .PIX_W (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pixel_in   (pixel_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .addr_in    (addr_in),
    .wr_data_in (wr_data_in),
    .write_en   (write_en),
    .rd_data_out(rd_data_out),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    addr_in    = a;
    wr_data_in = d;
    write_en   = 1'b1;
    tick();
    write_en   = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    addr_in = a;
    #1;
    d = rd_data_out;
  endtask

  // pixel value is the frame index; indices bad_a/bad_b are sent inverted
  task automatic stream(input int n, input int gap_pct, input int bad_a, input int bad_b,
                        output int dones);
    int sent;
    int cycles;
    sent   = 0;
    cycles = 0;
    dones  = 0;
    while (sent < n && cycles < 20000) begin
      valid_in = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      pixel_in = (pix_idx == bad_a || pix_idx == bad_b) ? ~pix_idx[7:0] : pix_idx[7:0];
      if (frame_done) dones++;
      if (valid_in && ready_out) begin
        sent++;
        pix_idx = (pix_idx + 1) % 1024;
      end
      tick();
      cycles++;
    end
    valid_in = 1'b0;
    total++;
    if (sent != n) begin
      bad++;
      $display("FAIL stream_timeout: sent=%0d want=%0d", sent, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int viol;
    rstn = 1'b0; valid_in = 1'b1; pixel_in = 8'h55;
    write_en = 1'b0; addr_in = 5'h04; wr_data_in = '0;
    repeat (3) tick();
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_out); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 00000000", d); end
    reg_read(5'h08, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_checksum: got %h want 00000000", d); end
    reg_read(5'h0C, d);
    total++; if (d !== 32'h000000FF) begin bad++; $display("FAIL reset_stats: got %h want 000000ff", d); end
    rstn = 1'b1;
    viol = 0;
    repeat (20) begin
      tick();
      if (ready_out || frame_done) viol++;
    end
    valid_in = 1'b0;
    total++; if (viol != 0) begin bad++; $display("FAIL idle_no_activity: got %0d want 0", viol); end
  endtask

  task automatic test_full_frame();
    logic [31:0] d;
    int dn;
    reg_write(5'h00, 32'h1);
    stream(1024, 0, -1, -1, dn);
    total++; if (dn != 0) begin bad++; $display("FAIL ff_early_done: got %0d want 0", dn); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ff_done: got %b want 1", frame_done); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL ff_stall: got %b want 0", ready_out); end
    reg_read(5'h04, d);
    tick();
    total++; if (frame_done !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL ff_resume: got done=%b ready=%b want done=0 ready=1", frame_done, ready_out);
    end
    reg_read(5'h08, d);
    total++; if (d !== 32'h0001FE00) begin bad++; $display("FAIL ff_checksum: got %h want 0001fe00", d); end
    reg_read(5'h0C, d);
    total++; if (d !== 32'h03FFFF00) begin bad++; $display("FAIL ff_stats: got %h want 03ffff00", d); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010001) begin bad++; $display("FAIL ff_status: got %h want 00010001", d); end
  endtask

  task automatic test_gaps();
    logic [31:0] d;
    int dn;
    reg_write(5'h00, 32'h3);
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010000) begin bad++; $display("FAIL gap_clr_status: got %h want 00010000", d); end
    pix_idx = 0;
    for (int f = 0; f < 3; f++) begin
      stream(1024, 30, -1, -1, dn);
      total++; if (frame_done !== 1'b1 || dn != 0) begin
        bad++; $display("FAIL gap_done_%0d: got done=%b early=%0d want 1/0", f, frame_done, dn);
      end
      tick();
      reg_read(5'h08, d);
      total++; if (d !== 32'h0001FE00) begin bad++; $display("FAIL gap_checksum_%0d: got %h want 0001fe00", f, d); end
    end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010003) begin bad++; $display("FAIL gap_status: got %h want 00010003", d); end
  endtask

  task automatic test_en_drop();
    logic [31:0] d;
    int dn;
    stream(500, 0, -1, -1, dn);
    reg_write(5'h00, 32'h0);
    tick();
    reg_read(5'h04, d);
    total++; if (d !== 32'h00000003) begin bad++; $display("FAIL drop_status: got %h want 00000003", d); end
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL drop_ready: got %b want 0", ready_out); end
    pix_idx = 0;
    reg_write(5'h00, 32'h1);
    stream(1024, 0, -1, -1, dn);
    total++; if (frame_done !== 1'b1 || dn != 0) begin
      bad++; $display("FAIL drop_done: got done=%b early=%0d want 1/0", frame_done, dn);
    end
    tick();
    reg_read(5'h08, d);
    total++; if (d !== 32'h0001FE00) begin bad++; $display("FAIL drop_checksum: got %h want 0001fe00", d); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010004) begin bad++; $display("FAIL drop_status2: got %h want 00010004", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int dn;
    int extra;
    reg_write(5'h00, 32'h5);
    stream(1024, 0, -1, -1, dn);
    total++; if (frame_done !== 1'b1 || dn != 0) begin
      bad++; $display("FAIL os_done: got done=%b early=%0d want 1/0", frame_done, dn);
    end
    valid_in = 1'b1;
    extra = 0;
    repeat (40) begin
      tick();
      if (frame_done || ready_out) extra++;
    end
    valid_in = 1'b0;
    total++; if (extra != 0) begin bad++; $display("FAIL os_after: got %0d want 0", extra); end
    reg_read(5'h00, d);
    total++; if (d !== 32'h00000004) begin bad++; $display("FAIL os_ctrl: got %h want 00000004", d); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00000005) begin bad++; $display("FAIL os_status: got %h want 00000005", d); end
  endtask

  task automatic test_clr_mid();
    logic [31:0] d;
    int dn;
    pix_idx = 0;
    reg_write(5'h00, 32'h1);
    stream(300, 0, -1, -1, dn);
    reg_write(5'h00, 32'h3);
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010000) begin bad++; $display("FAIL clr_status: got %h want 00010000", d); end
    reg_read(5'h0C, d);
    total++; if (d !== 32'h000000FF) begin bad++; $display("FAIL clr_stats: got %h want 000000ff", d); end
    reg_read(5'h08, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clr_checksum: got %h want 00000000", d); end
    pix_idx = 0;
    stream(1024, 0, -1, -1, dn);
    total++; if (frame_done !== 1'b1 || dn != 0) begin
      bad++; $display("FAIL clr_done: got done=%b early=%0d want 1/0", frame_done, dn);
    end
    tick();
    reg_read(5'h08, d);
    total++; if (d !== 32'h0001FE00) begin bad++; $display("FAIL clr_checksum2: got %h want 0001fe00", d); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010001) begin bad++; $display("FAIL clr_status2: got %h want 00010001", d); end
    reg_write(5'h08, 32'hFFFFFFFF);
    reg_read(5'h08, d);
    total++; if (d !== 32'h0001FE00) begin bad++; $display("FAIL ro_write: got %h want 0001fe00", d); end
    reg_read(5'h18, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped: got %h want 00000000", d); end
  endtask

  task automatic test_mismatch();
    logic [31:0] d;
    int dn;
`ifdef PIXEL_CHECK_EN
    reg_write(5'h10, 32'h5A);
    reg_read(5'h10, d);
    total++; if (d !== 32'h5A) begin bad++; $display("FAIL exp_base_rw: got %h want 0000005a", d); end
    reg_write(5'h10, 32'h0);
    reg_read(5'h14, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mis_init: got %h want 00000000", d); end
    stream(1024, 0, 10, 700, dn);
    tick();
    reg_read(5'h14, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL mis_count: got %h want 00000002", d); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00030002) begin bad++; $display("FAIL mis_status: got %h want 00030002", d); end
`else
    reg_write(5'h10, 32'hAB);
    reg_read(5'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL exp_base_off: got %h want 00000000", d); end
    stream(1024, 0, 10, 700, dn);
    tick();
    reg_read(5'h14, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mis_off: got %h want 00000000", d); end
    reg_read(5'h04, d);
    total++; if (d !== 32'h00010002) begin bad++; $display("FAIL mis_status_off: got %h want 00010002", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_en_drop();
    test_oneshot();
    test_clr_mid();
    test_mismatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
